// File: rtl/seq_mult_div.sv
// seq_mult_div: self-sequenced multi-cycle arithmetic unit.
// op=0 runs a radix-2 Booth signed multiply and op=1 runs a restoring unsigned
// divide. Each operation takes N iterations, one iteration per clock.
// A start/ready/done handshake sequences the unit. The result is held from
// one completed operation until the next one completes or is cleared.
module seq_mult_div #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [N-1:0]     Q,
    input  logic [N-1:0]     M,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [2*N-1:0]   result
);

    // The counter must hold the value N itself, so it needs clog2(N+1) bits.
    localparam int CW = $clog2(N + 1);
    // Packed working state: {A (N+1 bits), Q (N bits), q-1 (1 bit)}.
    localparam int SW = 2 * N + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DZ   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [N:0]        a_r;
    logic [N-1:0]      q_r;
    logic              qm1_r;
    logic [N-1:0]      m_r;
    logic              op_r;
    logic              dz_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              div_by_zero_r;
    logic [2*N-1:0]    result_r;
    logic [SW-1:0]     step_s;

    // One Booth iteration: add or subtract M based on {Q0, q-1}, then shift the
    // whole {A,Q,q-1} register right arithmetically. A is one bit wider than M,
    // so the case -2^(N-1) * -2^(N-1) cannot overflow.
    function automatic logic [SW-1:0] booth_step(
        input logic [N:0]   a,
        input logic [N-1:0] q,
        input logic         qm1,
        input logic [N-1:0] m
    );
        logic [N:0]    m_ext;
        logic [N:0]    a_sum;
        logic [SW-1:0] full;
        m_ext = {m[N-1], m};
        case ({q[0], qm1})
            2'b10:   a_sum = a - m_ext;
            2'b01:   a_sum = a + m_ext;
            default: a_sum = a;
        endcase
        full = {a_sum, q, qm1};
        return {full[SW-1], full[SW-1:1]};
    endfunction

    // One restoring-divide iteration: shift {A,Q} left and try A-M.
    // If the trial result is negative, keep the shifted A and set Q0=0.
    // Otherwise keep the trial result and set Q0=1.
    // A stays below M between iterations, so A[N] is always zero on entry.
    // The returned q-1 slot is unused for divide and is forced to zero.
    function automatic logic [SW-1:0] div_step(
        input logic [N:0]   a,
        input logic [N-1:0] q,
        input logic [N-1:0] m
    );
        logic [N:0]   a_sh;
        logic [N-1:0] q_sh;
        logic [N:0]   trial;
        a_sh  = {a[N-1:0], q[N-1]};
        q_sh  = {q[N-2:0], 1'b0};
        trial = a_sh - {1'b0, m};
        if (trial[N]) begin
            return {a_sh, q_sh, 1'b0};
        end else begin
            return {trial, q_sh[N-1:1], 1'b1, 1'b0};
        end
    endfunction

    // Next working-register value for the operation currently in flight.
    always_comb begin
        step_s = '0;
        if (op_r) begin
            step_s = div_step(a_r, q_r, m_r);
        end else begin
            step_s = booth_step(a_r, q_r, qm1_r, m_r);
        end
    end

    // Control FSM, iteration counter, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            a_r           <= '0;
            q_r           <= '0;
            qm1_r         <= 1'b0;
            m_r           <= '0;
            op_r          <= 1'b0;
            dz_r          <= 1'b0;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            div_by_zero_r <= 1'b0;
            result_r      <= '0;
        end else if (clear) begin
            // An abort drops the operation in flight and wipes the visible result.
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            dz_r          <= 1'b0;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            div_by_zero_r <= 1'b0;
            result_r      <= '0;
        end else begin
            // done is a single-cycle pulse; only the DONE exit raises it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= '0;
                        q_r     <= Q;
                        m_r     <= M;
                        qm1_r   <= 1'b0;
                        op_r    <= op;
                        cnt_r   <= CW'(N);
                        ready_r <= 1'b0;
                        if (op && (M == {N{1'b0}})) begin
                            dz_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DZ;
                        end else begin
                            dz_r    <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    a_r   <= step_s[SW-1:N+1];
                    q_r   <= step_s[N:1];
                    qm1_r <= step_s[0];
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_CALC;
                    end
                end
                ST_DZ: begin
                    // Divide by zero yields remainder=dividend and quotient=all ones.
                    a_r     <= {1'b0, q_r};
                    q_r     <= {N{1'b1}};
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    result_r      <= {a_r[N-1:0], q_r};
                    div_by_zero_r <= dz_r;
                    done_r        <= 1'b1;
                    ready_r       <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = div_by_zero_r;
    assign result      = result_r;

endmodule

// File: tb/tb_seq_mult_div.sv
// tb_seq_mult_div: self-checking bench for seq_mult_div at N=8 and N=4.
// Both instances share their inputs. Only the selected instance's outputs
// are observed. A plain-arithmetic reference model supplies every
// expected result.
module tb_seq_mult_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic        op;
    logic [7:0]  q_in;
    logic [7:0]  m_in;

    logic        ready8, busy8, done8, dz8;
    logic [15:0] res8;
    logic        ready4, busy4, done4, dz4;
    logic [7:0]  res4;

    int          sel_n = 8;
    logic        ready_s, busy_s, done_s, dz_s;
    logic [15:0] result_s;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult_div #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .op(op),
        .Q(q_in), .M(m_in), .ready(ready8), .busy(busy8), .done(done8),
        .div_by_zero(dz8), .result(res8)
    );

    seq_mult_div #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .op(op),
        .Q(q_in[3:0]), .M(m_in[3:0]), .ready(ready4), .busy(busy4), .done(done4),
        .div_by_zero(dz4), .result(res4)
    );

    assign ready_s  = (sel_n == 4) ? ready4 : ready8;
    assign busy_s   = (sel_n == 4) ? busy4  : busy8;
    assign done_s   = (sel_n == 4) ? done4  : done8;
    assign dz_s     = (sel_n == 4) ? dz4    : dz8;
    assign result_s = (sel_n == 4) ? {8'h00, res4} : res8;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {div_by_zero, result} from plain integer arithmetic.
    function automatic logic [16:0] ref_model(input int n, input bit opv, input int q, input int m);
        int qs, ms, p;
        int mask_n, mask_2n;
        logic [16:0] r;
        mask_n  = (1 << n) - 1;
        mask_2n = (1 << (2 * n)) - 1;
        if (!opv) begin
            qs = (q >= (1 << (n - 1))) ? q - (1 << n) : q;
            ms = (m >= (1 << (n - 1))) ? m - (1 << n) : m;
            p  = qs * ms;
            r  = {1'b0, 16'(p & mask_2n)};
        end else if (m == 0) begin
            r  = {1'b1, 16'((q << n) | mask_n)};
        end else begin
            r  = {1'b0, 16'(((q % m) << n) | (q / m))};
        end
        return r;
    endfunction

    // One operation; poke_at>0 re-pulses start with junk operands on that edge after the start edge.
    task automatic do_op(input int n, input bit opv, input int q, input int m, input int poke_at,
                         output int lat, output logic [15:0] res, output logic dz_o);
        sel_n = n;
        check_eq("ready_before", 32'(ready_s), 32'd1);
        op    = opv;
        q_in  = q[7:0];
        m_in  = m[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        q_in  = 8'($urandom);
        m_in  = 8'($urandom);
        check_eq("ready_drop", 32'(ready_s), 32'd0);
        check_eq("done_pulse_end", 32'(done_s), 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (poke_at != 0 && lat == poke_at - 1) begin
                start = 1'b1;
                op    = 1'($urandom);
                q_in  = 8'($urandom);
                m_in  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (done_s) break;
        end
        start = 1'b0;
        res   = result_s;
        dz_o  = dz_s;
    endtask

    task automatic run_check(input int n, input bit opv, input int q, input int m);
        int          lat;
        logic [15:0] res;
        logic        dz;
        logic [16:0] e;
        e = ref_model(n, opv, q, m);
        do_op(n, opv, q, m, 0, lat, res, dz);
        check_eq("rnd_result", 32'(res), 32'(e[15:0]));
        check_eq("rnd_dz", 32'(dz), 32'(e[16]));
        check_eq("rnd_latency", 32'(lat), e[16] ? 32'd2 : 32'(n + 1));
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | done_s;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] res;
        logic        dz;

        rst = 1'b0; clear = 1'b0; start = 1'b0; op = 1'b0; q_in = 8'h00; m_in = 8'h00;
        tick();
        tick();
        check_eq("rst_ready", 32'(ready_s), 32'd1);
        check_eq("rst_busy", 32'(busy_s), 32'd0);
        check_eq("rst_done", 32'(done_s), 32'd0);
        check_eq("rst_dz", 32'(dz_s), 32'd0);
        check_eq("rst_result", 32'(result_s), 32'd0);
        rst = 1'b1;
        tick();

        // Directed cases at N=8, issued back to back.
        do_op(8, 1'b0, 32'hFD, 32'h05, 0, lat, res, dz);
        check_eq("mul_m3x5", 32'(res), 32'h0000FFF1);
        check_eq("mul_m3x5_lat", 32'(lat), 32'd9);
        check_eq("mul_m3x5_dz", 32'(dz), 32'd0);
        do_op(8, 1'b0, 32'h80, 32'h80, 0, lat, res, dz);
        check_eq("mul_min_min", 32'(res), 32'h00004000);
        check_eq("mul_b2b_lat", 32'(lat), 32'd9);
        do_op(8, 1'b1, 200, 7, 0, lat, res, dz);
        check_eq("div_200_7", 32'(res), 32'h0000041C);
        check_eq("div_200_7_lat", 32'(lat), 32'd9);
        do_op(8, 1'b1, 13, 0, 0, lat, res, dz);
        check_eq("div_zero_res", 32'(res), 32'h00000DFF);
        check_eq("div_zero_lat", 32'(lat), 32'd2);
        check_eq("div_zero_flag", 32'(dz), 32'd1);
        do_op(8, 1'b1, 100, 9, 0, lat, res, dz);
        check_eq("div_after_dz_flag", 32'(dz), 32'd0);
        check_eq("div_100_9", 32'(res), 32'h0000010B);

        // A start pulse while busy is ignored and does not queue.
        do_op(8, 1'b0, 32'hFD, 32'h05, 3, lat, res, dz);
        check_eq("ignored_start_res", 32'(res), 32'h0000FFF1);
        check_eq("ignored_start_lat", 32'(lat), 32'd9);
        tick();
        check_eq("no_queue_done", 32'(done_s), 32'd0);
        check_eq("no_queue_ready", 32'(ready_s), 32'd1);

        // Asynchronous reset in the middle of an operation.
        op = 1'b1; q_in = 8'd200; m_in = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check_eq("arst_ready", 32'(ready_s), 32'd1);
        check_eq("arst_busy", 32'(busy_s), 32'd0);
        check_eq("arst_result", 32'(result_s), 32'd0);
        check_eq("arst_done", 32'(done_s), 32'd0);
        tick();
        rst = 1'b1;
        no_done_for("arst_no_done", 15);
        check_eq("arst_idle_ready", 32'(ready_s), 32'd1);

        // Synchronous clear mid-operation, after a divide-by-zero set the flag.
        do_op(8, 1'b1, 13, 0, 0, lat, res, dz);
        check_eq("pre_clear_dz", 32'(dz), 32'd1);
        op = 1'b1; q_in = 8'd200; m_in = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_ready", 32'(ready_s), 32'd1);
        check_eq("clr_busy", 32'(busy_s), 32'd0);
        check_eq("clr_result", 32'(result_s), 32'd0);
        check_eq("clr_dz", 32'(dz_s), 32'd0);
        check_eq("clr_done", 32'(done_s), 32'd0);
        no_done_for("clr_no_done", 12);

        // clear wins over a simultaneous start.
        op = 1'b0; q_in = 8'd3; m_in = 8'd3; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check_eq("clr_prio_ready", 32'(ready_s), 32'd1);
        check_eq("clr_prio_busy", 32'(busy_s), 32'd0);
        no_done_for("clr_prio_no_done", 12);

        // Randomized operations at N=8.
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                int q, m;
                q = int'($urandom_range(255));
                m = int'($urandom_range(255));
                if (mode == 1 && (i % 50) == 0) m = 0;
                run_check(8, 1'(mode), q, m);
            end
        end

        // N=4: exhaustive, then randomized.
        for (int mode = 0; mode < 2; mode++) begin
            for (int q = 0; q < 16; q++) begin
                for (int m = 0; m < 16; m++) begin
                    run_check(4, 1'(mode), q, m);
                end
            end
        end
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                run_check(4, 1'(mode), int'($urandom_range(15)), int'($urandom_range(15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
